// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: show-ahead read port, level flags,
// sticky overflow and a saturating dropped-byte counter.
module uart_rx_fifo #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int AFULL_LEVEL = 12,
   parameter int DATA_W      = 8
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic              RX_DONE,
   input  logic              RD_EN,
   input  logic              CLEAR,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              EMPTY,
   output logic              FULL,
   output logic              ALMOST_FULL,
   output logic [ADDR_W:0]   COUNT,
   output logic              OVERFLOW,
   output logic [7:0]        DROP_COUNT
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [7:0]        drop_count;
   logic              wr;
   logic              rd;
   logic              drop;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // CLEAR suppresses every other action in its cycle, including drop counting.
   always_comb begin
      wr   = RX_DONE & (~FULL | RD_EN) & ~CLEAR;
      rd   = RD_EN & ~EMPTY & ~CLEAR;
      drop = RX_DONE & FULL & ~RD_EN & ~CLEAR;
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr && !RESET)
         mem[wr_ptr] <= RX_DATA;
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'h00;
      end else if (CLEAR) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'h00;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc(drop_count);
         end
      end
   end

   always_comb begin
      EMPTY       = (count == '0);
      FULL        = (count == DEPTH_C);
      ALMOST_FULL = (count >= AFULL_C);
      COUNT       = count;
      OVERFLOW    = overflow;
      DROP_COUNT  = drop_count;
      RD_DATA     = EMPTY ? '0 : mem[rd_ptr];
   end

endmodule
